// File: rtl/timer_pkg.sv
// Shared definitions for the timer interrupt controller:
// source indices, source count and controller FSM states.
package timer_pkg;

  localparam int NUM_TIMER_IRQ = 12;

  localparam int SRC_CMIA0 = 0;
  localparam int SRC_CMIA1 = 1;
  localparam int SRC_CMIA2 = 2;
  localparam int SRC_CMIA3 = 3;
  localparam int SRC_CMIB0 = 4;
  localparam int SRC_CMIB1 = 5;
  localparam int SRC_CMIB2 = 6;
  localparam int SRC_CMIB3 = 7;
  localparam int SRC_OVI0  = 8;
  localparam int SRC_OVI1  = 9;
  localparam int SRC_OVI2  = 10;
  localparam int SRC_OVI3  = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } intc_state_t;

endpackage

// File: rtl/timer_intc_prio.sv
// Lowest-index-wins priority encoder for the interrupt candidates.
// Index 0 (CMIA0) has the highest priority.
module timer_intc_prio #(
  parameter int N = 12,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/timer_intc.sv
// Timer interrupt controller: edge detect, pending/enable, fixed priority, req/ack/eoi.
// Define TIMER_INTC_LOST_EN to add the sticky per-source 'lost' flags.
module timer_intc
  import timer_pkg::*;
#(
  parameter int NUM_SRC   = NUM_TIMER_IRQ,
  parameter int VEC_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   irq_src,
  input  logic                 en_we,
  input  logic [NUM_SRC-1:0]   en_wdata,
  input  logic [NUM_SRC-1:0]   pend_clr,
  input  logic                 irq_ack,
  input  logic                 irq_eoi,
  output logic                 irq_req,
  output logic [VEC_WIDTH-1:0] irq_vec,
  output logic [NUM_SRC-1:0]   enable,
  output logic [NUM_SRC-1:0]   pending,
  output logic                 in_service
`ifdef TIMER_INTC_LOST_EN
  ,
  output logic [NUM_SRC-1:0]   lost
`endif
);

  logic [NUM_SRC-1:0]   src_q;
  logic [NUM_SRC-1:0]   pend_q;
  logic [NUM_SRC-1:0]   pend_d;
  logic [NUM_SRC-1:0]   en_q;
  logic [NUM_SRC-1:0]   en_d;
  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   ack_clr;
  logic [NUM_SRC-1:0]   cand;
  logic [VEC_WIDTH-1:0] vec_q;
  logic [VEC_WIDTH-1:0] vec_d;
  logic [VEC_WIDTH-1:0] win_idx;
  logic                 win_valid;
  logic                 ack_take;
  intc_state_t          state_q;
  intc_state_t          state_d;

  assign rise     = irq_src & ~src_q;
  assign ack_take = (state_q == REQ) && irq_ack;
  assign ack_clr  = ack_take ? (NUM_SRC'(1) << vec_q) : '0;
  // A fresh edge beats any clear landing on the same bit.
  assign pend_d   = (pend_q & ~pend_clr & ~ack_clr) | rise;
  assign en_d     = en_we ? en_wdata : en_q;
  assign cand     = pend_q & en_q;

  timer_intc_prio #(
    .N (NUM_SRC),
    .W (VEC_WIDTH)
  ) u_prio (
    .req   (cand),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          vec_d   = win_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        if (irq_ack) state_d = SVC;
      end
      SVC: begin
        if (irq_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q   <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      vec_q   <= '0;
      state_q <= IDLE;
    end else begin
      src_q   <= irq_src;
      pend_q  <= pend_d;
      en_q    <= en_d;
      vec_q   <= vec_d;
      state_q <= state_d;
    end
  end

  assign irq_req    = (state_q == REQ);
  assign in_service = (state_q == SVC);
  assign irq_vec    = vec_q;
  assign enable     = en_q;
  assign pending    = pend_q;

`ifdef TIMER_INTC_LOST_EN
  logic [NUM_SRC-1:0] lost_q;
  logic [NUM_SRC-1:0] lost_d;

  // An edge onto a bit that stays pending means one event was merged away.
  assign lost_d = (lost_q & ~pend_clr)
                | (rise & pend_q & ~pend_clr & ~ack_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lost_q <= '0;
    else     lost_q <= lost_d;
  end

  assign lost = lost_q;
`endif

endmodule
